// File: rtl/codificacao_carga_if.sv
// codificacao_carga_if: field-bundle handshake plus instruction-memory write bus
// between a field source (master) and the encoder/loader (slave).
interface codificacao_carga_if #(parameter int ADDR_WIDTH = 5);
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            tipo;
   logic [4:0]            rd;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [11:0]           immediate;
   logic                  last;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [ADDR_WIDTH:0]   count;
   logic                  busy;
   logic                  done;
   logic                  erro;
   modport master (
      output start, in_valid, tipo, rd, rs1, rs2, funct3, funct7, immediate, last,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, erro
   );
   modport slave (
      input  start, in_valid, tipo, rd, rs1, rs2, funct3, funct7, immediate, last,
      output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, erro
   );
endinterface

// File: rtl/codificacao_carga.sv
// codificacao_carga: packs decoded fields into 32-bit RISC-V words and writes
// them to consecutive instruction-memory addresses, one word per two cycles.
module codificacao_carga #(
   parameter int ADDR_WIDTH = 5,
   parameter int BASE_ADDR  = 0
) (
   input logic                clk,
   input logic                rst_n,
   codificacao_carga_if.slave bus
);
   typedef enum logic [2:0] {OCIOSO, RECEBE, ESCREVE, FIM, ERRO} state_t;
   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic [31:0]           wdata_q;
   logic                  last_q;
   logic                  we_q;
   logic                  ready_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  erro_q;
   logic [6:0]            opc;
   logic [31:0]           enc_d;
   logic                  tipo_ok;
   logic                  full;
   always_comb begin
      opc     = {bus.tipo, 4'b0011};
      tipo_ok = !bus.tipo[2] || bus.tipo == 3'b110;
      enc_d   = (bus.tipo == 3'b011) ? {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, opc} :
                bus.tipo[1]          ? {bus.immediate[11:5], bus.rs2, bus.rs1, bus.funct3,
                                        bus.immediate[4:0], opc} :
                                       {bus.immediate, bus.rs1, bus.funct3, bus.rd, opc};
      full    = count_q == {1'b0, {ADDR_WIDTH{1'b1}}};
   end
   // Outputs are registered alongside the state so they always reflect it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCIOSO;
         addr_q  <= '0;
         count_q <= '0;
         wdata_q <= '0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         case (state_q)
            OCIOSO, FIM, ERRO: if (bus.start) begin
               state_q <= RECEBE;
               addr_q  <= ADDR_WIDTH'(BASE_ADDR);
               count_q <= '0;
               done_q  <= 1'b0;
               erro_q  <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b1;
            end
            RECEBE: if (bus.in_valid) begin
               ready_q <= 1'b0;
               if (tipo_ok) begin
                  state_q <= ESCREVE;
                  wdata_q <= enc_d;
                  last_q  <= bus.last;
                  we_q    <= 1'b1;
               end else begin
                  state_q <= ERRO;
                  erro_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            ESCREVE: begin
               we_q    <= 1'b0;
               count_q <= count_q + 1'b1;
               addr_q  <= addr_q + 1'b1;
               if (last_q || full) begin
                  state_q <= FIM;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= RECEBE;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= OCIOSO;
         endcase
      end
   end
   assign bus.in_ready  = ready_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.count     = count_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.erro      = erro_q;
endmodule

// File: tb/tb_codificacao_carga.sv
// tb_codificacao_carga: directed vectors with hand-encoded words against a
// 32-word loader (ia) and a 4-word loader (ib) sharing clock, reset and fields.
module tb_codificacao_carga;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   codificacao_carga_if #(.ADDR_WIDTH(5)) ia ();
   codificacao_carga_if #(.ADDR_WIDTH(2)) ib ();
   codificacao_carga #(.ADDR_WIDTH(5), .BASE_ADDR(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   codificacao_carga #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
   assign ib.tipo      = ia.tipo;
   assign ib.rd        = ia.rd;
   assign ib.rs1       = ia.rs1;
   assign ib.rs2       = ia.rs2;
   assign ib.funct3    = ia.funct3;
   assign ib.funct7    = ia.funct7;
   assign ib.immediate = ia.immediate;
   assign ib.last      = ia.last;
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic fields(input logic [2:0] t, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [11:0] imm, input logic l);
      ia.tipo = t; ia.rd = d; ia.rs1 = s1; ia.rs2 = s2;
      ia.funct3 = f3; ia.funct7 = f7; ia.immediate = imm; ia.last = l;
   endtask
   // Offers the current fields for one cycle and checks the resulting write.
   task automatic send(input bit sel, input logic [31:0] exp_w, input logic [31:0] exp_a);
      chk("ready_before", 32'(sel ? ib.in_ready : ia.in_ready), 1);
      if (sel) ib.in_valid = 1'b1; else ia.in_valid = 1'b1;
      @(negedge clk);
      ia.in_valid = 1'b0;
      ib.in_valid = 1'b0;
      chk("we_pulse", 32'(sel ? ib.mem_we : ia.mem_we), 1);
      chk("addr", sel ? 32'(ib.mem_addr) : 32'(ia.mem_addr), exp_a);
      chk("wdata", sel ? ib.mem_wdata : ia.mem_wdata, exp_w);
      chk("ready_in_write", 32'(sel ? ib.in_ready : ia.in_ready), 0);
      @(negedge clk);
      chk("we_single", 32'(sel ? ib.mem_we : ia.mem_we), 0);
   endtask
   task automatic start_a();
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
   endtask
   initial begin
      rst_n = 1'b0;
      ia.start = 1'b0; ia.in_valid = 1'b0;
      ib.start = 1'b0; ib.in_valid = 1'b0;
      fields(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ia.in_ready), 0);
      chk("rst_busy", 32'(ia.busy), 0);
      chk("rst_we", 32'(ia.mem_we), 0);
      chk("rst_addr", 32'(ia.mem_addr), 0);
      chk("rst_count", 32'(ia.count), 0);
      chk("rst_done", 32'(ia.done), 0);
      chk("rst_erro", 32'(ia.erro), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(ia.in_ready), 0);
      // addi x1,x0,5 with garbage in the ignored rs2/funct7
      start_a();
      chk("busy_recebe", 32'(ia.busy), 1);
      fields(3'b001, 1, 0, 31, 0, 7'h7f, 12'd5, 1);
      send(0, 32'h00500093, 0);
      chk("t1_done", 32'(ia.done), 1);
      chk("t1_count", 32'(ia.count), 1);
      chk("t1_busy", 32'(ia.busy), 0);
      // add x3,x1,x2 then sw x2,8(x1) with garbage rd
      start_a();
      chk("t2_done_clr", 32'(ia.done), 0);
      fields(3'b011, 3, 1, 2, 0, 0, 12'hfff, 0);
      send(0, 32'h002081B3, 0);
      fields(3'b010, 31, 1, 2, 2, 7'h55, 12'd8, 1);
      send(0, 32'h0020A423, 1);
      chk("t2_done", 32'(ia.done), 1);
      chk("t2_count", 32'(ia.count), 2);
      // start with in_valid in FIM: only start acted on, then back-to-back bundles
      fields(3'b000, 5, 1, 0, 2, 0, 12'd4, 0);
      ia.start = 1'b1;
      ia.in_valid = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      chk("t3_not_taken", 32'(ia.mem_we), 0);
      chk("t3_ready", 32'(ia.in_ready), 1);
      chk("t3_count0", 32'(ia.count), 0);
      @(negedge clk);
      chk("t3_we", 32'(ia.mem_we), 1);
      chk("t3_wdata", ia.mem_wdata, 32'h0040A283);
      chk("t3_ready_low", 32'(ia.in_ready), 0);
      fields(3'b001, 1, 0, 0, 0, 0, 12'd5, 1);
      @(negedge clk);
      chk("t3_gap_we", 32'(ia.mem_we), 0);
      chk("t3_gap_ready", 32'(ia.in_ready), 1);
      @(negedge clk);
      ia.in_valid = 1'b0;
      chk("t3_we2", 32'(ia.mem_we), 1);
      chk("t3_addr2", 32'(ia.mem_addr), 1);
      chk("t3_wdata2", ia.mem_wdata, 32'h00500093);
      @(negedge clk);
      chk("t3_done", 32'(ia.done), 1);
      chk("t3_count", 32'(ia.count), 2);
      // invalid tipo after one good write
      start_a();
      fields(3'b001, 1, 0, 0, 0, 0, 12'd5, 0);
      send(0, 32'h00500093, 0);
      fields(3'b101, 1, 2, 3, 0, 0, 12'd1, 0);
      ia.in_valid = 1'b1;
      @(negedge clk);
      ia.in_valid = 1'b0;
      chk("t4_erro", 32'(ia.erro), 1);
      chk("t4_no_we", 32'(ia.mem_we), 0);
      chk("t4_ready", 32'(ia.in_ready), 0);
      chk("t4_busy", 32'(ia.busy), 0);
      chk("t4_count", 32'(ia.count), 1);
      @(negedge clk);
      chk("t4_no_we2", 32'(ia.mem_we), 0);
      chk("t4_erro_held", 32'(ia.erro), 1);
      start_a();
      chk("t4_erro_clr", 32'(ia.erro), 0);
      chk("t4_restart_ready", 32'(ia.in_ready), 1);
      // reset while writing the second word
      fields(3'b011, 3, 1, 2, 0, 0, 0, 0);
      send(0, 32'h002081B3, 0);
      ia.in_valid = 1'b1;
      @(negedge clk);
      ia.in_valid = 1'b0;
      chk("t6_we_pre", 32'(ia.mem_we), 1);
      chk("t6_addr_pre", 32'(ia.mem_addr), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_we", 32'(ia.mem_we), 0);
      chk("t6_busy", 32'(ia.busy), 0);
      chk("t6_count", 32'(ia.count), 0);
      chk("t6_addr", 32'(ia.mem_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_ready", 32'(ia.in_ready), 0);
      chk("t6_busy_after", 32'(ia.busy), 0);
      // 4-word memory fills without last
      ib.start = 1'b1;
      @(negedge clk);
      ib.start = 1'b0;
      fields(3'b110, 0, 1, 2, 1, 0, 12'hfff, 0);
      send(1, 32'hFE209FE3, 0);
      fields(3'b011, 4, 1, 2, 0, 0, 0, 0);
      send(1, 32'h00208233, 1);
      fields(3'b011, 5, 1, 2, 0, 0, 0, 0);
      send(1, 32'h002082B3, 2);
      chk("t5_not_done", 32'(ib.done), 0);
      fields(3'b011, 6, 1, 2, 0, 0, 0, 0);
      send(1, 32'h00208333, 3);
      chk("t5_done", 32'(ib.done), 1);
      chk("t5_count", 32'(ib.count), 4);
      chk("t5_ready", 32'(ib.in_ready), 0);
      chk("t5_addr_wrap", 32'(ib.mem_addr), 0);
      ib.in_valid = 1'b1;
      @(negedge clk);
      ib.in_valid = 1'b0;
      chk("t5_ignored", 32'(ib.mem_we), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/codificacao_carga.md
Name: codificacao_carga

Overview:
Instruction encoder and loader: the inverse of the decode stage. Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit RISC-V words. Supported formats are I-load, I-ALU, S, R and SB. Each word is written into instruction memory at consecutive addresses. Used by the bench and boot path to fill instruction memory before the datapath runs.

Parameters:
ADDR_WIDTH, 5, instruction-memory word-address width (2^ADDR_WIDTH words)
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load session (honoured only in OCIOSO, FIM, ERRO)
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
tipo  input  3  format: 000 I-load, 001 I-ALU, 010 S, 011 R, 110 SB
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field
immediate  input  12  raw 12-bit immediate
last  input  1  marks the final bundle of the session
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_WIDTH  word address
mem_wdata  output  32  encoded instruction
count  output  ADDR_WIDTH+1  words written this session
busy  output  1  high in RECEBE and ESCREVE
done  output  1  session completed; held until the next start
erro  output  1  invalid tipo received; held until the next start

Behaviour:
- Reset (async, rst_n=0):
  - state=OCIOSO.
  - All outputs 0; mem_addr=0.
  - Memory contents already written are untouched.
- Encoding (combinational from inputs, registered on accept):
  - opcode[6:4]=tipo, opcode[3:0]=0011.
  - I (000/001): imm[11:0], rs1, funct3, rd, opcode. rs2 and funct7 are ignored.
  - S and SB (010/110): [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0], opcode. rd and funct7 are ignored. SB immediate is the raw 12-bit field; no bit shuffling or shifting.
  - R (011): funct7, rs2, rs1, funct3, rd, opcode. immediate is ignored.
  - tipo 100, 101, 111: invalid.
- FSM states:
  - OCIOSO: in_ready=0. start -> RECEBE; mem_addr<=BASE_ADDR, count<=0, done<=0, erro<=0.
  - RECEBE: in_ready=1, busy=1.
    - in_valid with valid tipo: mem_wdata<=encoded word, latch last -> ESCREVE.
    - in_valid with invalid tipo: erro<=1, no write -> ERRO.
    - in_valid=0: stay.
  - ESCREVE: in_ready=0, mem_we=1 for exactly this one cycle. On exit: count<=count+1, mem_addr<=mem_addr+1 (wraps modulo 2^ADDR_WIDTH).
    - latched last=1, or count+1 == 2^ADDR_WIDTH (memory full): done<=1 -> FIM.
    - otherwise -> RECEBE.
  - FIM / ERRO: in_ready=0, flags held. start -> RECEBE with the same initialisation as from OCIOSO.
- Timing:
  - Throughput: one word per 2 cycles.
  - mem_we rises the cycle after the accepting edge.
  - mem_addr and mem_wdata are stable while mem_we=1.
- start is ignored in RECEBE and ESCREVE.
- in_valid is ignored outside RECEBE; bundles offered there are not consumed.
- start together with in_valid in OCIOSO: only start is acted on. The bundle is accepted no earlier than the next cycle.
- Reset mid-session returns to OCIOSO immediately. Partially written words remain in memory; count reads 0.

Test Plan:
- start; addi x1,x0,5 (tipo=001, rd=1, rs1=0, f3=0, imm=5, last=1) -> mem_we at addr 0, mem_wdata=0x00500093, count=1, done=1.
- start; add x3,x1,x2 (tipo=011, f7=0, rs2=2, rs1=1, f3=0, rd=3) then sw x2,8(x1) (tipo=010, f3=2, imm=8, last=1) -> 0x002081B3 @0, 0x0020A423 @1, count=2, done=1.
- lw x5,4(x1) (tipo=000, rd=5, rs1=1, f3=2, imm=4) with in_valid held high back-to-back -> 0x0040A283 written; in_ready low in ESCREVE; the next bundle is accepted exactly 2 cycles later.
- tipo=101 offered in RECEBE -> erro=1, no mem_we pulse, count unchanged; new start clears erro.
- ADDR_WIDTH=2, 4 bundles with last=0 -> writes to addrs 0..3, done=1 after the 4th write, count=4, in_ready=0 afterwards.
- rst_n pulled low during ESCREVE -> mem_we, busy, count, mem_addr go to 0 asynchronously; after release, state is OCIOSO with in_ready=0.
